// File: rtl/data_mem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester indices and
// the starvation threshold.
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    VGA = 2'd0,
    CPU = 2'd1,
    KBD = 2'd2
  } req_idx_e;

  localparam int unsigned STARVE_W     = 3;
  localparam int unsigned STARVE_LIMIT = 7;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin between cpu and kbd: the one granted last loses a tie.
module arb_rr2 (
  input  logic clk,
  input  logic rst,
  input  logic cpu_req,
  input  logic kbd_req,
  input  logic upd_en,
  input  logic upd_cpu,
  output logic pick_kbd_c
);

  logic prefer_kbd_q, prefer_kbd_d;

  assign pick_kbd_c = kbd_req && (!cpu_req || prefer_kbd_q);

  always_comb begin
    prefer_kbd_d = prefer_kbd_q;
    if (upd_en) prefer_kbd_d = upd_cpu;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prefer_kbd_q <= 1'b0;
    else     prefer_kbd_q <= prefer_kbd_d;
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Three-port arbiter (vga fixed-high, cpu/kbd round-robin) in front of a
// synchronous-read RAM. Define DATA_MEM_ARB_STARVE_GUARD_EN to let a starved cpu/kbd beat vga.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned DEPTH  = 256,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic              vga_we,
  input  logic [ADDR_W-1:0] vga_addr,
  input  logic [DATA_W-1:0] vga_wdata,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              kbd_req,
  input  logic              kbd_we,
  input  logic [ADDR_W-1:0] kbd_addr,
  input  logic [DATA_W-1:0] kbd_wdata,
  output logic              kbd_gnt,
  output logic              kbd_rvalid,
  output logic [DATA_W-1:0] kbd_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  req_idx_e          win_q, win_d, win_c;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]        gnt_q, gnt_d, rvalid_q, rvalid_d;

  logic              any_req_c, arb_c, rr_cpu_req_c, rr_kbd_req_c, rr_kbd_c;
  logic              sel_we_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_wdata_c;

  assign any_req_c = vga_req || cpu_req || kbd_req;
  assign arb_c     = (state_q == IDLE) && any_req_c;

  arb_rr2 u_rr (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (rr_cpu_req_c),
    .kbd_req    (rr_kbd_req_c),
    .upd_en     (arb_c && (win_c != VGA)),
    .upd_cpu    (win_c == CPU),
    .pick_kbd_c (rr_kbd_c)
  );

`ifdef DATA_MEM_ARB_STARVE_GUARD_EN
  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] cpu_cnt_q, cpu_cnt_d, kbd_cnt_q, kbd_cnt_d;
  logic                cpu_st_c, kbd_st_c;

  assign cpu_st_c     = cpu_req && (cpu_cnt_q == LIMIT);
  assign kbd_st_c     = kbd_req && (kbd_cnt_q == LIMIT);
  // Starved requesters compete only among themselves, ahead of vga.
  assign rr_cpu_req_c = (cpu_st_c || kbd_st_c) ? cpu_st_c : cpu_req;
  assign rr_kbd_req_c = (cpu_st_c || kbd_st_c) ? kbd_st_c : kbd_req;

  always_comb begin
    win_c = VGA;
    if (cpu_st_c || kbd_st_c) win_c = rr_kbd_c ? KBD : CPU;
    else if (vga_req)         win_c = VGA;
    else if (rr_kbd_c)        win_c = KBD;
    else if (cpu_req)         win_c = CPU;
  end

  always_comb begin
    cpu_cnt_d = cpu_cnt_q;
    kbd_cnt_d = kbd_cnt_q;
    if (arb_c) begin
      if (win_c == CPU)                     cpu_cnt_d = '0;
      else if (cpu_req && cpu_cnt_q != LIMIT) cpu_cnt_d = cpu_cnt_q + STARVE_W'(1);
      if (win_c == KBD)                     kbd_cnt_d = '0;
      else if (kbd_req && kbd_cnt_q != LIMIT) kbd_cnt_d = kbd_cnt_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_cnt_q <= '0;
      kbd_cnt_q <= '0;
    end else begin
      cpu_cnt_q <= cpu_cnt_d;
      kbd_cnt_q <= kbd_cnt_d;
    end
  end
`else
  assign rr_cpu_req_c = cpu_req;
  assign rr_kbd_req_c = kbd_req;

  always_comb begin
    win_c = VGA;
    if (vga_req)       win_c = VGA;
    else if (rr_kbd_c) win_c = KBD;
    else if (cpu_req)  win_c = CPU;
  end
`endif

  always_comb begin
    sel_we_c    = vga_we;
    sel_addr_c  = vga_addr;
    sel_wdata_c = vga_wdata;
    case (win_c)
      CPU: begin
        sel_we_c    = cpu_we;
        sel_addr_c  = cpu_addr;
        sel_wdata_c = cpu_wdata;
      end
      KBD: begin
        sel_we_c    = kbd_we;
        sel_addr_c  = kbd_addr;
        sel_wdata_c = kbd_wdata;
      end
      default: ;
    endcase
  end

  // The memory address/data flops double as the latched request payload.
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    gnt_d       = '0;
    rvalid_d    = '0;
    case (state_q)
      IDLE: begin
        if (any_req_c) begin
          state_d      = ISSUE;
          win_d        = win_c;
          mem_we_d     = sel_we_c;
          mem_addr_d   = sel_addr_c;
          mem_wdata_d  = sel_wdata_c;
          gnt_d[win_c] = 1'b1;
        end
      end
      ISSUE: begin
        if (mem_we_q) begin
          state_d = IDLE;
        end else begin
          state_d         = RESP;
          rvalid_d[win_q] = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      win_q       <= VGA;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  assign vga_gnt    = gnt_q[VGA];
  assign cpu_gnt    = gnt_q[CPU];
  assign kbd_gnt    = gnt_q[KBD];
  assign vga_rvalid = rvalid_q[VGA];
  assign cpu_rvalid = rvalid_q[CPU];
  assign kbd_rvalid = rvalid_q[KBD];

  // Read data passes straight from the RAM during RESP, gated to the winner.
  assign vga_rdata = rvalid_q[VGA] ? mem_rdata : '0;
  assign cpu_rdata = rvalid_q[CPU] ? mem_rdata : '0;
  assign kbd_rdata = rvalid_q[KBD] ? mem_rdata : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural synchronous-read RAM.
module tb_data_mem_arbiter;

  localparam int unsigned DW  = 32;
  localparam int unsigned DEP = 256;
  localparam int unsigned AW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          vga_req, vga_we, vga_gnt, vga_rvalid;
  logic [AW-1:0] vga_addr;
  logic [DW-1:0] vga_wdata, vga_rdata;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          kbd_req, kbd_we, kbd_gnt, kbd_rvalid;
  logic [AW-1:0] kbd_addr;
  logic [DW-1:0] kbd_wdata, kbd_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] ram [DEP];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc;
  int gq[$], gc[$], rq[$], rc[$];
  logic [DW-1:0] rdq[$];
  bit we_seen;

  always #5 clk = ~clk;

  data_mem_arbiter #(.DATA_W(DW), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst),
    .vga_req(vga_req), .vga_we(vga_we), .vga_addr(vga_addr), .vga_wdata(vga_wdata),
    .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .kbd_req(kbd_req), .kbd_we(kbd_we), .kbd_addr(kbd_addr), .kbd_wdata(kbd_wdata),
    .kbd_gnt(kbd_gnt), .kbd_rvalid(kbd_rvalid), .kbd_rdata(kbd_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // RAM model; known read contents are reloaded whenever reset is held.
  always @(posedge clk) begin
    if (rst) begin
      ram[8'h01] <= 32'h1111_1111;
      ram[8'h02] <= 32'h2222_2222;
      ram[8'h03] <= 32'h3333_3333;
      ram[8'h05] <= 32'h5555_5555;
      ram[8'h06] <= 32'h6666_6666;
      ram[8'h10] <= 32'hDEAD_BEEF;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic clr();
    gq.delete(); gc.delete(); rq.delete(); rc.delete(); rdq.delete();
    we_seen = 1'b0;
    cyc     = 0;
  endtask

  // Advance one cycle, sample at the falling edge, log events, drop served reqs.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (mem_we) we_seen = 1'b1;
    if (vga_gnt) begin gq.push_back(0); gc.push_back(cyc); vga_req = 1'b0; end
    if (cpu_gnt) begin gq.push_back(1); gc.push_back(cyc); cpu_req = 1'b0; end
    if (kbd_gnt) begin gq.push_back(2); gc.push_back(cyc); kbd_req = 1'b0; end
    if (vga_rvalid) begin rq.push_back(0); rc.push_back(cyc); rdq.push_back(vga_rdata); end
    if (cpu_rvalid) begin rq.push_back(1); rc.push_back(cyc); rdq.push_back(cpu_rdata); end
    if (kbd_rvalid) begin rq.push_back(2); rc.push_back(cyc); rdq.push_back(kbd_rdata); end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vga_req = 1'b0; cpu_req = 1'b0; kbd_req = 1'b0;
    vga_we  = 1'b0; cpu_we  = 1'b0; kbd_we  = 1'b0;
    vga_addr = '0; cpu_addr = '0; kbd_addr = '0;
    vga_wdata = '0; cpu_wdata = '0; kbd_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int nc, nk, cnt_cpu, cnt_vga;

    // Reset values and a single cpu read
    rst = 1'b1;
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_gnts", 32'({vga_gnt, cpu_gnt, kbd_gnt}), 32'd0);
    chk("rst_rvalids", 32'({vga_rvalid, cpu_rvalid, kbd_rvalid}), 32'd0);
    chk("rst_rdata", vga_rdata | cpu_rdata | kbd_rdata, 32'd0);
    rst = 1'b0;
    clr();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    tick();
    chk("rd_cpu_gnt", 32'(cpu_gnt), 32'd1);
    chk("rd_mem_addr", 32'(mem_addr), 32'h10);
    tick();
    chk("rd_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("rd_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("rd_cpu_gnt_off", 32'(cpu_gnt), 32'd0);
    chk("rd_vga_rdata", vga_rdata, 32'd0);
    tick();
    chk("rd_rvalid_off", 32'(cpu_rvalid), 32'd0);
    chk("rd_no_we", 32'(we_seen), 32'd0);

    // Three simultaneous reads
    do_reset();
    clr();
    vga_req = 1'b1; vga_addr = 8'h01;
    cpu_req = 1'b1; cpu_addr = 8'h02;
    kbd_req = 1'b1; kbd_addr = 8'h03;
    repeat (10) tick();
    chk("all_n_gnt", 32'(gq.size()), 32'd3);
    chk("all_n_rvalid", 32'(rq.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < gq.size()) begin
        chk($sformatf("all_gnt_who%0d", i), 32'(gq[i]), 32'(i));
        chk($sformatf("all_gnt_cyc%0d", i), 32'(gc[i]), 32'(1 + 3 * i));
      end
      if (i < rq.size()) begin
        chk($sformatf("all_rv_cyc%0d", i), 32'(rc[i]), 32'(2 + 3 * i));
        chk($sformatf("all_rv_data%0d", i), rdq[i], 32'h1111_1111 * 32'(i + 1));
      end
    end

    // cpu/kbd back-to-back writes alternate
    do_reset();
    clr();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h40; cpu_wdata = 32'hC000_0000;
    kbd_req = 1'b1; kbd_we = 1'b1; kbd_addr = 8'h50; kbd_wdata = 32'hB000_0000;
    nc = 1; nk = 1;
    repeat (14) begin
      tick();
      if (!cpu_req && nc < 3) begin
        cpu_addr = AW'(8'h40 + nc); cpu_wdata = 32'hC000_0000 + 32'(nc); cpu_req = 1'b1; nc++;
      end
      if (!kbd_req && nk < 3) begin
        kbd_addr = AW'(8'h50 + nk); kbd_wdata = 32'hB000_0000 + 32'(nk); kbd_req = 1'b1; nk++;
      end
    end
    chk("wr_n_gnt", 32'(gq.size()), 32'd6);
    chk("wr_no_rvalid", 32'(rq.size()), 32'd0);
    for (int i = 0; i < 6; i++) begin
      if (i < gq.size()) begin
        chk($sformatf("wr_gnt_who%0d", i), 32'(gq[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
        chk($sformatf("wr_gnt_cyc%0d", i), 32'(gc[i]), 32'(1 + 2 * i));
      end
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("wr_ram_cpu%0d", k), ram[8'h40 + k], 32'hC000_0000 + 32'(k));
      chk($sformatf("wr_ram_kbd%0d", k), ram[8'h50 + k], 32'hB000_0000 + 32'(k));
    end

    // vga hammering while cpu waits
    do_reset();
    clr();
    vga_req = 1'b1; vga_addr = 8'h01;
    cpu_req = 1'b1; cpu_addr = 8'h02;
    repeat (50) begin
      tick();
      if (!vga_req) vga_req = 1'b1;
    end
    cnt_cpu = 0; cnt_vga = 0;
    foreach (gq[i]) begin
      if (gq[i] == 1) cnt_cpu++;
      if (gq[i] == 0) cnt_vga++;
    end
`ifdef DATA_MEM_ARB_STARVE_GUARD_EN
    chk("starve_cpu_cnt", 32'(cnt_cpu), 32'd1);
    if (gq.size() > 7) begin
      chk("starve_8th_is_cpu", 32'(gq[7]), 32'd1);
      chk("starve_cpu_cyc", 32'(gc[7]), 32'd22);
    end else begin
      chk("starve_n_gnt", 32'(gq.size()), 32'd16);
    end
`else
    chk("starve_cpu_cnt", 32'(cnt_cpu), 32'd0);
    chk("starve_vga_cnt", 32'(cnt_vga), 32'd17);
`endif

    // Reset aborting ISSUE, then RESP, of a kbd read, then normal service
    do_reset();
    clr();
    kbd_req = 1'b1; kbd_we = 1'b0; kbd_addr = 8'h05;
    tick();
    chk("abort_iss_gnt", 32'(kbd_gnt), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_iss_gnt_off", 32'(kbd_gnt), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    kbd_req = 1'b1; kbd_addr = 8'h05;
    tick();
    chk("abort_resp_gnt", 32'(kbd_gnt), 32'd1);
    @(posedge clk);
    rst = 1'b1;
    #1;
    chk("abort_resp_rvalid", 32'(kbd_rvalid), 32'd0);
    chk("abort_resp_rdata", kbd_rdata, 32'd0);
    chk("abort_resp_addr", 32'(mem_addr), 32'd0);
    tick();
    tick();
    chk("abort_no_rvalid", 32'(rq.size()), 32'd0);
    rst = 1'b0;
    clr();
    kbd_req = 1'b1; kbd_addr = 8'h06;
    tick();
    chk("after_gnt", 32'(kbd_gnt), 32'd1);
    tick();
    chk("after_rvalid", 32'(kbd_rvalid), 32'd1);
    chk("after_rdata", kbd_rdata, 32'h6666_6666);
    chk("after_no_we", 32'(we_seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, memory word width in bits.
REQ-002 SHALL have parameter DEPTH, default 256, memory words; ADDR_W = $clog2(DEPTH).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have, per requester p in {vga, cpu, kbd}: p_req input 1, p_we input 1, p_addr input ADDR_W, p_wdata input DATA_W, p_gnt output 1, p_rvalid output 1, p_rdata output DATA_W.
REQ-006 SHALL have mem_we output 1, mem_addr output ADDR_W, mem_wdata output DATA_W, mem_rdata input DATA_W; the RAM is synchronous-read, 1-cycle latency.

Function
REQ-007 SHALL implement FSM states IDLE, ISSUE, RESP.
REQ-008 IDLE: if any req is high, SHALL latch winner's we/addr/wdata and move to ISSUE; otherwise stay.
REQ-009 Priority: vga fixed highest; cpu and kbd SHALL round-robin between themselves, the last-granted of the two losing a tie.
REQ-010 ISSUE: SHALL drive mem_addr/mem_wdata from latched values, mem_we = latched we, pulse winner's p_gnt for exactly one cycle.
REQ-011 ISSUE write: SHALL return to IDLE next cycle; no rvalid.
REQ-012 ISSUE read: SHALL move to RESP; in RESP SHALL pulse winner's p_rvalid for one cycle with p_rdata = mem_rdata, then return to IDLE.
REQ-013 Latency: request seen in IDLE at cycle N -> gnt at N+1 -> rvalid at N+2; next arbitration at N+2 (write) or N+3 (read).
REQ-014 Requester SHALL hold req and payload until gnt; arbiter SHALL ignore payload changes after latching.
REQ-015 p_rdata of non-served ports SHALL be 0; at most one gnt and one rvalid high per cycle.
REQ-016 mem_we SHALL be 0 in every state except ISSUE of a write.
REQ-017 A req deasserted before latch SHALL never be served; simultaneous requests on all three SHALL all be served in three successive transactions.

Reset
REQ-018 rst SHALL asynchronously force IDLE, mem_we=0, mem_addr=0, mem_wdata=0, all gnt/rvalid=0, all rdata=0, round-robin pointer to cpu-first, starvation counters to 0.
REQ-019 Reset during ISSUE or RESP SHALL abort the transaction with no gnt/rvalid emitted after rst rises.

Configuration
REQ-020 Macro DATA_MEM_ARB_STARVE_GUARD_EN: when defined, SHALL keep a 3-bit counter per cpu/kbd, incremented each IDLE arbitration that requester loses, cleared on its grant; at count 7 that requester SHALL beat vga.
REQ-021 When undefined, vga SHALL always win and no counters SHALL exist.

Structure
REQ-022 Shared package data_mem_arb_pkg SHALL hold state enum (IDLE, ISSUE, RESP), requester-index enum (VGA=0, CPU=1, KBD=2) and STARVE_LIMIT=7.
REQ-023 One sub-module, arb_rr2, SHALL hold the cpu/kbd round-robin pointer and tie-break.

Verification
REQ-024 After reset, cpu read addr 0x10 (RAM[0x10]=0xDEADBEEF) -> cpu_gnt at +1, cpu_rvalid with 0xDEADBEEF at +2, mem_we=0 throughout.
REQ-025 vga, cpu, kbd request same cycle (all reads) -> grant order vga, cpu, kbd; rvalid cycles spaced 3 apart.
REQ-026 cpu and kbd write continuously -> grants alternate cpu, kbd, cpu...; each write two cycles; RAM contents match.
REQ-027 vga held high constantly, cpu requesting: macro off -> cpu never granted over 50 cycles; macro on -> cpu granted after 7 lost arbitrations.
REQ-028 rst asserted in RESP of a kbd read -> kbd_rvalid never pulses, outputs 0 same cycle, next request after release served normally.
